// File: rtl/if_fetch_if.sv
// Byte-wide memory read bus between the instruction fetch stage and the
// memory controller. The fetch stage is the master: it raises mem_req with a
// byte address and the controller answers with mem_ready/mem_data.
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [7:0]  mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage. Assembles a 32-bit little-endian instruction from
// four byte reads on the memory bus, presents it to decode with if_valid and
// holds it while decode stalls. jmp_enable flushes any fetch in flight.
// rst is asynchronous and active low.
//
// Optional feature: define ICACHE_EN to add a direct-mapped instruction cache
// of ICACHE_LINES words. A hit in IDLE delivers the word one cycle after
// enable_pc without touching the memory bus; a completed miss fills the line.
module if_fetch #(
  parameter int ICACHE_LINES = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc,
  input  logic          enable_pc,
  input  logic          jmp_enable,
  input  logic          stall_in,
  output logic          stall_req,
  if_fetch_if.master    mem,
  output logic [31:0]   if_inst,
  output logic [31:0]   if_pc,
  output logic          if_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [1:0]  cnt;
  logic [23:0] byte_buf;
  logic [31:0] fill_word;
  logic        last_byte;

  // The last byte goes straight into the output word, so only three are buffered.
  assign fill_word = {mem.mem_data, byte_buf};
  assign last_byte = (state == FETCH) && !jmp_enable && mem.mem_ready && (cnt == 2'd3);

  // Bus request and back-pressure follow directly from the state register,
  // so both collapse to zero the moment reset forces IDLE.
  assign mem.mem_req  = (state == FETCH);
  assign mem.mem_addr = fetch_pc + {30'd0, cnt};
  assign stall_req    = (state != IDLE);

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]             cache_data [ICACHE_LINES];
  logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cache_valid;
  logic [IDX_W-1:0]        lookup_idx;
  logic [TAG_W-1:0]        lookup_tag;
  logic [IDX_W-1:0]        fill_idx;
  logic [TAG_W-1:0]        fill_tag;
  logic                    cache_hit;
  logic [31:0]             cache_rd;

  assign lookup_idx = pc[IDX_W+1:2];
  assign lookup_tag = pc[31:IDX_W+2];
  assign fill_idx   = fetch_pc[IDX_W+1:2];
  assign fill_tag   = fetch_pc[31:IDX_W+2];
  assign cache_hit  = cache_valid[lookup_idx] && (cache_tag[lookup_idx] == lookup_tag);
  assign cache_rd   = cache_data[lookup_idx];

  // Valid bits are the only cache state that must be cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid <= '0;
    end else if (last_byte) begin
      cache_valid[fill_idx] <= 1'b1;
    end
  end

  // Line data and tag are written only when a miss completes without a flush.
  always_ff @(posedge clk) begin
    if (last_byte) begin
      cache_data[fill_idx] <= fill_word;
      cache_tag[fill_idx]  <= fill_tag;
    end
  end
`endif

  // Fetch sequencer: IDLE accepts a new pc, FETCH collects four bytes,
  // HOLD keeps the instruction on the outputs until decode takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= '0;
      cnt      <= '0;
      byte_buf <= '0;
      if_inst  <= '0;
      if_pc    <= '0;
      if_valid <= 1'b0;
    end else if (jmp_enable) begin
      state    <= IDLE;
      cnt      <= '0;
      if_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_pc) begin
            fetch_pc <= pc;
            cnt      <= '0;
`ifdef ICACHE_EN
            if (cache_hit) begin
              if_inst  <= cache_rd;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= HOLD;
            end else begin
              state    <= FETCH;
            end
`else
            state    <= FETCH;
`endif
          end
        end
        FETCH: begin
          if (mem.mem_ready) begin
            case (cnt)
              2'd0: byte_buf[7:0]   <= mem.mem_data;
              2'd1: byte_buf[15:8]  <= mem.mem_data;
              2'd2: byte_buf[23:16] <= mem.mem_data;
              default: begin
                if_inst  <= fill_word;
                if_pc    <= fetch_pc;
                if_valid <= 1'b1;
                state    <= HOLD;
              end
            endcase
            cnt <= cnt + 2'd1;
          end
        end
        HOLD: begin
          if (!stall_in) begin
            if_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter ICACHE_LINES, default 32, number of direct-mapped instruction-cache lines (power of two; used only when ICACHE_EN is defined).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-004 pc  input  32  fetch address from PC generator; word-aligned.
REQ-005 enable_pc  input  1  pc is a new fetch address this cycle.
REQ-006 jmp_enable  input  1  redirect/flush; abort any in-flight fetch.
REQ-007 stall_in  input  1  decode stage not accepting; hold output.
REQ-008 stall_req  output  1  to PC generator; high while busy or holding an unaccepted output.
REQ-009 mem_req  output  1  byte read request to memory controller.
REQ-010 mem_addr  output  32  byte address of current request.
REQ-011 mem_ready  input  1  memory controller returns mem_data this cycle.
REQ-012 mem_data  input  8  returned byte.
REQ-013 if_inst  output  32  assembled instruction.
REQ-014 if_pc  output  32  address of if_inst.
REQ-015 if_valid  output  1  if_inst/if_pc valid.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD.
REQ-017 IDLE: when enable_pc=1 and jmp_enable=0, latch pc into fetch_pc, clear byte counter, go to FETCH; stall_req SHALL be 1 from the next cycle.
REQ-018 FETCH: mem_req=1, mem_addr=fetch_pc+cnt, cnt 2-bit (0..3).
REQ-019 On mem_ready in FETCH, mem_data SHALL be written to byte cnt of the instruction buffer (little-endian: byte 0 -> bits 7:0) and cnt incremented.
REQ-020 After the byte with cnt=3 is accepted, next cycle: if_valid=1, if_inst=buffer, if_pc=fetch_pc, state HOLD, mem_req=0.
REQ-021 Miss latency without stall: if_valid SHALL rise exactly 1 cycle after the 4th mem_ready.
REQ-022 HOLD: if stall_in=0, if_valid drops next cycle, stall_req drops, go to IDLE; if stall_in=1, if_inst/if_pc/if_valid SHALL remain unchanged.
REQ-023 stall_req SHALL be 1 in FETCH and HOLD, 0 in IDLE.
REQ-024 jmp_enable=1 in any state: next cycle state=IDLE, mem_req=0, if_valid=0, cnt=0; a mem_ready in the flush cycle SHALL be discarded.
REQ-025 jmp_enable and enable_pc together: jmp_enable wins; no fetch starts that cycle.
REQ-026 enable_pc while not IDLE SHALL be ignored.
REQ-027 mem_addr arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+3 = 0xFFFFFFFF).

Reset
REQ-028 While rst=0, immediately and regardless of clk: state=IDLE, cnt=0, mem_req=0, mem_addr=0, stall_req=0, if_valid=0, if_inst=0, if_pc=0.
REQ-029 Reset asserted mid-FETCH SHALL abandon the fetch; no partial instruction appears after release.
REQ-030 First fetch SHALL be accepted on the first posedge with rst=1 and enable_pc=1.

Configuration
REQ-031 Macro ICACHE_EN: when defined, a direct-mapped cache of ICACHE_LINES words SHALL be included; index=pc[log2(ICACHE_LINES)+1:2], tag=remaining upper bits, one valid bit per line.
REQ-032 With ICACHE_EN, hit at enable_pc in IDLE: no mem_req; next cycle if_valid=1 with cached word, state HOLD (1-cycle latency).
REQ-033 With ICACHE_EN, a completed miss SHALL write word, tag, valid=1 into the line in the same cycle if_valid rises; aborted fetches SHALL NOT write.
REQ-034 With ICACHE_EN, rst=0 SHALL clear all valid bits.
REQ-035 Without ICACHE_EN, every fetch SHALL go to memory per REQ-017..021; no cache storage synthesized.

Verification
REQ-036 pc=0x100, enable_pc=1, mem_ready every cycle with bytes 0x13,0x05,0x10,0x00 -> if_inst=0x00100513, if_pc=0x100, if_valid=1 one cycle after 4th byte.
REQ-037 Same fetch with stall_in=1 for 3 cycles after if_valid -> outputs stable 3 cycles, if_valid drops 1 cycle after stall_in=0.
REQ-038 jmp_enable=1 after 2 bytes of fetch at 0x200 -> mem_req=0 and if_valid=0 next cycle; new fetch at 0x300 returns 0x300 word only.
REQ-039 rst=0 pulsed between clock edges during FETCH -> all outputs zero immediately; no if_valid after release until a new enable_pc.
REQ-040 ICACHE_EN: fetch 0x100 (miss, 4 mem_ready), flush, refetch 0x100 -> no mem_req, if_valid one cycle after enable_pc; fetch 0x180 (same index, different tag) -> miss.
REQ-041 pc=0xFFFFFFFC -> mem_addr sequence 0xFFFFFFFC..0xFFFFFFFF, no wrap error.
